// File: rtl/cpu_pkg.sv
// cpu_pkg -- constants and types shared by the fetch stage and main control.
//   Opcode constants, the NOP encoding, and the fetch-stage FSM state type.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_STOP  = 6'd63;

   // All-zero word decodes as SLL $0,$0,0: architecturally a no-op.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg -- IF/ID pipeline register.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : load instr_i / pc4_i and mark valid
//   clr_i      : squash to a bubble (NOP, invalid); pc4 is kept; wins over en_i
//   instr_i    : fetched instruction word
//   pc4_i      : PC+4 of the fetched instruction
//   instr_o, pc4_o, valid_o : registered contents
module if_id_reg
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [ADDR_W-1:0]  pc4_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  pc4_o,
   output logic               valid_o
);

   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  pc4_q;
   logic               valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= INSTR_W'(NOP_INSTR);
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else if (clr_i) begin
         instr_q <= INSTR_W'(NOP_INSTR);
         valid_q <= 1'b0;
      end else if (en_i) begin
         instr_q <= instr_i;
         pc4_q   <= pc4_i;
         valid_q <= 1'b1;
      end
   end

   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage with the IF/ID register.
//   clk, rst_n    : clock, asynchronous active-low reset
//   stall_i       : hold PC and IF/ID (load-use hazard)
//   flush_i       : squash IF/ID, load word-aligned redirect_pc_i into PC
//   redirect_pc_i : branch/jump target resolved in EX
//   imem_addr_o   : current PC, imem is read combinationally
//   imem_rdata_i  : instruction at imem_addr_o
//   if_id_instr_o, if_id_pc4_o, if_id_valid_o : IF/ID register contents
//   opcode_o, func_o : decode fields of the IF/ID instruction for main control
//   halted_o      : pipeline drained after STOP; sticky until reset
module if_stage
   import cpu_pkg::*;
#(
   parameter int               ADDR_W       = 32,
   parameter int               INSTR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int               DRAIN_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_i,
   input  logic               flush_i,
   input  logic [ADDR_W-1:0]  redirect_pc_i,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic [INSTR_W-1:0] if_id_instr_o,
   output logic [ADDR_W-1:0]  if_id_pc4_o,
   output logic               if_id_valid_o,
   output logic [5:0]         opcode_o,
   output logic [5:0]         func_o,
   output logic               halted_o
);

   localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

   fetch_state_t      state_q, state_d;
   logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;
   logic              adv, clr;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] redirect_aligned;

   assign pc_plus4 = pc_q + ADDR_W'(4);   // wraps mod 2^ADDR_W by construction
   // Masking rather than slicing keeps the target word-aligned.
   assign redirect_aligned = redirect_pc_i & ~ADDR_W'(3);

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      halted_d    = halted_q;
      pc_d        = pc_q;
      adv         = 1'b0;
      clr         = 1'b0;
      unique case (state_q)
         RUN: begin
            if (flush_i) begin
               pc_d = redirect_aligned;
               clr  = 1'b1;
            end else if (!stall_i) begin
               adv  = 1'b1;
               pc_d = pc_plus4;
               // The edge that loads STOP still advances the PC; it freezes afterwards.
               if (imem_rdata_i[31:26] == OP_STOP) begin
                  state_d     = DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         DRAIN: begin
            // STOP on a mispredicted path: abandon the drain.
            if (flush_i) begin
               pc_d        = redirect_aligned;
               clr         = 1'b1;
               state_d     = RUN;
               drain_cnt_d = '0;
            end else if (drain_cnt_q == CNT_LAST) begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         HALTED: begin
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         drain_cnt_q <= '0;
         pc_q        <= RESET_PC;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         pc_q        <= pc_d;
         halted_q    <= halted_d;
      end
   end

   if_id_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_if_id (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (adv),
      .clr_i   (clr),
      .instr_i (imem_rdata_i),
      .pc4_i   (pc_plus4),
      .instr_o (if_id_instr_o),
      .pc4_o   (if_id_pc4_o),
      .valid_o (if_id_valid_o)
   );

   assign imem_addr_o = pc_q;
   assign opcode_o    = if_id_instr_o[31:26];
   assign func_o      = if_id_instr_o[5:0];
   assign halted_o    = halted_q;

endmodule
